// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a request-to-send,
// shifts one odd-parity byte out on device clocks and checks the acknowledge.
//
// state     | meaning
// IDLE      | lines released, waiting for tx_valid
// INHIBIT   | holding PS2 clock low; start bit asserted in the last cycle
// SEND      | clock released, shifting start/data/parity/stop on device falls
// ACK       | waiting for the 11th fall to sample the device acknowledge
// WAIT_IDLE | waiting for both lines to float high before reporting done
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t                r_state;
  logic                  r_c_s1, r_c_s2, r_d_s1, r_d_s2;
  logic [FILTER_LEN-1:0] r_c_sh, r_d_sh;
  logic                  r_c_filt, r_d_filt, r_c_filt_q;
  logic                  r_fall, r_edge;
  logic [IW-1:0]         r_inh_cnt;
  logic [TW-1:0]         r_to_cnt;
  logic [9:0]            r_frame;
  logic [3:0]            r_n;
  logic                  r_tx_ready, r_ps2c_oe, r_ps2d_oe, r_busy, r_done, r_ack_ok, r_err;

  logic w_active;
  logic w_to_exp;
  logic w_line_idle;
  logic w_abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c_s1     <= 1'b1;
      r_c_s2     <= 1'b1;
      r_d_s1     <= 1'b1;
      r_d_s2     <= 1'b1;
      r_c_sh     <= '1;
      r_d_sh     <= '1;
      r_c_filt   <= 1'b1;
      r_d_filt   <= 1'b1;
      r_c_filt_q <= 1'b1;
      r_fall     <= 1'b0;
      r_edge     <= 1'b0;
    end else begin
      r_c_s1 <= ps2c_in;
      r_c_s2 <= r_c_s1;
      r_d_s1 <= ps2d_in;
      r_d_s2 <= r_d_s1;
      r_c_sh <= {r_c_sh[FILTER_LEN-2:0], r_c_s2};
      r_d_sh <= {r_d_sh[FILTER_LEN-2:0], r_d_s2};
      if (&r_c_sh)       r_c_filt <= 1'b1;
      else if (~|r_c_sh) r_c_filt <= 1'b0;
      if (&r_d_sh)       r_d_filt <= 1'b1;
      else if (~|r_d_sh) r_d_filt <= 1'b0;
      r_c_filt_q <= r_c_filt;
      r_fall     <= r_c_filt_q & ~r_c_filt;
      r_edge     <= r_c_filt_q ^ r_c_filt;
    end
  end

  assign w_active    = (r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
  assign w_to_exp    = (r_to_cnt == '0);
  assign w_line_idle = r_c_filt && r_d_filt;
  // A fall (or any clock edge) in the expiry cycle wins over the timeout.
  assign w_abort     = w_active && w_to_exp && !r_edge &&
                       !((r_state == S_WAIT_IDLE) && w_line_idle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_inh_cnt  <= '0;
      r_to_cnt   <= '0;
      r_frame    <= '1;
      r_n        <= '0;
      r_tx_ready <= 1'b1;
      r_ps2c_oe  <= 1'b0;
      r_ps2d_oe  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ack_ok   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_active) begin
        if (r_edge)         r_to_cnt <= TW'(TIMEOUT_CYCLES - 1);
        else if (!w_to_exp) r_to_cnt <= r_to_cnt - 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_tx_ready <= 1'b1;
          if (tx_valid && r_tx_ready) begin
            r_frame    <= {1'b1, ~^tx_data, tx_data};
            r_ack_ok   <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b1;
            r_tx_ready <= 1'b0;
            r_ps2c_oe  <= 1'b1;
            r_ps2d_oe  <= (INHIBIT_CYCLES == 1);
            r_inh_cnt  <= IW'(INHIBIT_CYCLES - 1);
            r_state    <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (r_inh_cnt == '0) begin
            r_ps2c_oe <= 1'b0;
            r_n       <= '0;
            r_to_cnt  <= TW'(TIMEOUT_CYCLES - 1);
            r_state   <= S_SEND;
          end else begin
            if (r_inh_cnt == IW'(1)) r_ps2d_oe <= 1'b1;
            r_inh_cnt <= r_inh_cnt - 1'b1;
          end
        end

        S_SEND: begin
          if (r_fall) begin
            r_ps2d_oe <= ~r_frame[0];
            r_frame   <= {1'b1, r_frame[9:1]};
            r_n       <= r_n + 1'b1;
            if (r_n == 4'd9) r_state <= S_ACK;
          end
        end

        S_ACK: begin
          if (r_fall) begin
            r_ack_ok <= ~r_d_filt;
            r_err    <= r_d_filt;
            r_state  <= S_WAIT_IDLE;
          end
        end

        S_WAIT_IDLE: begin
          if (w_line_idle) begin
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_tx_ready <= 1'b0;
            r_state    <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase

      if (w_abort) begin
        r_ps2c_oe  <= 1'b0;
        r_ps2d_oe  <= 1'b0;
        r_err      <= 1'b1;
        r_ack_ok   <= 1'b0;
        r_done     <= 1'b1;
        r_busy     <= 1'b0;
        r_tx_ready <= 1'b0;
        r_state    <= S_IDLE;
      end
    end
  end

  assign tx_ready = r_tx_ready;
  assign ps2c_oe  = r_ps2c_oe;
  assign ps2d_oe  = r_ps2d_oe;
  assign busy     = r_busy;
  assign done     = r_done;
  assign ack_ok   = r_ack_ok;
  assign err      = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks the frame out of the
// host, and a scoreboard checks each done pulse against the expected result.
module tb_ps2_host_tx;

  localparam int INH  = 60;
  localparam int TO   = 3000;
  localparam int FL   = 8;
  localparam int HALF = 40;

  localparam int M_ACK    = 0;
  localparam int M_NOACK  = 1;
  localparam int M_SILENT = 2;
  localparam int M_GLITCH = 3;
  localparam int M_RST5   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2c_oe, ps2d_oe, busy, done, ack_ok, err;
  logic       dev_c_low = 1'b0, dev_d_low = 1'b0, glitch = 1'b0;
  logic       w_ps2c, w_ps2d;

  // Open-collector wiring: any party pulling low wins.
  assign w_ps2c = ~(ps2c_oe | dev_c_low | glitch);
  assign w_ps2d = ~(ps2d_oe | dev_d_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2c_in(w_ps2c), .ps2d_in(w_ps2d), .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe),
    .busy(busy), .done(done), .ack_ok(ack_ok), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       exp_ack;
    logic       chk_frame;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_e;
  int          total = 0;
  int          bad = 0;
  logic [10:0] rx_bits = '1;
  logic        fall5_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Wire frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = $countones(d);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no transfer at %0t", $time);
      end else begin
        m_e = sb.pop_front();
        check("ack_ok", ack_ok, m_e.exp_ack);
        check("err", err, !m_e.exp_ack);
        check("busy_at_done", busy, 1'b0);
        check("tx_ready_at_done", tx_ready, 1'b0);
        if (m_e.chk_frame) check("wire_frame", rx_bits, frame_of(m_e.data));
      end
    end
  end

  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst) prev_done <= 1'b0;
    else begin
      if (prev_done) begin
        check("done_one_cycle", done, 1'b0);
        check("tx_ready_after_done", tx_ready, 1'b1);
        check("ps2c_oe_after_done", ps2c_oe, 1'b0);
        check("ps2d_oe_after_done", ps2d_oe, 1'b0);
      end
      prev_done <= done;
    end
  end

  int inh_len = 0;
  int both_len = 0;
  always @(negedge clk) begin
    if (!rst) begin
      inh_len  = 0;
      both_len = 0;
    end else if (ps2c_oe) begin
      inh_len++;
      if (ps2d_oe) both_len++;
    end else if (inh_len != 0) begin
      check("inhibit_len", inh_len, INH);
      check("start_overlap", both_len, 1);
      inh_len  = 0;
      both_len = 0;
    end
  end

  // Behavioural PS/2 device: samples the line before each fall it generates.
  task automatic device(input int mode);
    int n;
    rx_bits = '1;
    n = 0;
    while (!ps2c_oe && n < 200) begin @(negedge clk); n++; end
    if (!ps2c_oe) begin fail_now("dev_wait_inhibit"); return; end
    n = 0;
    while (ps2c_oe && n < INH + 50) begin @(negedge clk); n++; end
    if (ps2c_oe) begin fail_now("dev_wait_release"); return; end
    check("start_bit_driven", ps2d_oe, 1'b1);
    if (mode == M_SILENT) return;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      rx_bits[k] = w_ps2d;
      if (k == 10 && mode != M_NOACK) begin
        dev_d_low = 1'b1;
        repeat (HALF / 2) @(negedge clk);
      end
      dev_c_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_c_low = 1'b0;
      if (mode == M_RST5 && k == 4) begin
        fall5_seen = 1'b1;
        return;
      end
      if (mode == M_GLITCH && k == 3) begin
        repeat (HALF / 2) @(negedge clk);
        glitch = 1'b1;
        repeat (3) @(negedge clk);
        glitch = 1'b0;
        repeat (HALF / 2 - 3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    dev_d_low = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input int mode);
    exp_t e;
    int n;
    e.data      = d;
    e.exp_ack   = (mode == M_ACK || mode == M_GLITCH);
    e.chk_frame = (mode != M_SILENT);
    if (mode != M_RST5) sb.push_back(e);
    n = 0;
    while (!tx_ready && n < 100) begin @(negedge clk); n++; end
    if (!tx_ready) fail_now("wait_tx_ready");
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 6000) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      fail_now("wait_done");
      sb.delete();
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic run(input logic [7:0] d, input int mode, input bit poke);
    fork
      send(d, mode);
      device(mode);
      begin
        if (poke) begin
          repeat (200) @(negedge clk);
          tx_data  = 8'h55;
          tx_valid = 1'b1;
          repeat (20) @(negedge clk);
          tx_valid = 1'b0;
        end
      end
    join
    wait_drain();
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_ps2c_oe", ps2c_oe, 1'b0);
    check("rst_ps2d_oe", ps2d_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ack_ok", ack_ok, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    run(8'hED, M_ACK, 1'b0);
    run(8'h00, M_ACK, 1'b1);
    for (int i = 0; i < 4; i++) run(8'($urandom_range(0, 255)), M_ACK, 1'b0);
    run(8'($urandom_range(0, 255)), M_NOACK, 1'b0);
    run(8'($urandom_range(0, 255)), M_SILENT, 1'b0);
    run(8'($urandom_range(0, 255)), M_GLITCH, 1'b0);

    fall5_seen = 1'b0;
    fork
      send(8'hA5, M_RST5);
      device(M_RST5);
    join
    n = 0;
    while (!fall5_seen && n < 10) begin @(negedge clk); n++; end
    if (!fall5_seen) fail_now("reach_fall5");
    check("busy_before_rst", busy, 1'b1);
    check("ps2d_oe_before_rst", ps2d_oe, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_ps2c_oe", ps2c_oe, 1'b0);
    check("async_rst_ps2d_oe", ps2d_oe, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    run(8'hFF, M_ACK, 1'b0);
    run(8'($urandom_range(0, 255)), M_ACK, 1'b0);

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
